cla_nibble_sequencer: RTL and testbench

- Multi-cycle WIDTH-bit add/subtract controller that time-shares one external 4-bit carry_look_ahead slice, one nibble per clock, LSB nibble first.
- Owns operand/result registers, ripples the carry between nibbles, and presents a valid/ready handshake to the KGPminiRISC execute stage.
- Used where area matters more than latency, e.g. the multi-cycle ALU path.

---
 rtl/cla_nibble_sequencer.sv | 115 +++++++++++
 tb/tb_cla_nibble_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract that time-shares one external 4-bit CLA slice, LSB nibble first.
// Optional subtract support is enabled with the CLA_SEQ_SUB_EN macro; the default build is add-only.
module cla_nibble_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic [3:0]       p,
  output logic [3:0]       g,
  output logic             c_in,
  input  logic [3:0]       carry,
  input  logic             c_out
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [NIB-1:0][3:0]    a_r, b_r, sum_r;
  logic                   carry_reg;
  logic [3:0]             an, bn, sum_nib;

  assign an      = a_r[idx];
  assign bn      = b_r[idx];
  assign sum_nib = p ^ {carry[2:0], c_in};
  assign sum     = sum_r;
  assign zero    = (sum_r == '0);

`ifndef CLA_SEQ_SUB_EN
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
`endif

  // Slice is driven straight from registers so its carries come back the same cycle.
  always_comb begin
    p    = 4'h0;
    g    = 4'h0;
    c_in = 1'b0;
    if (state == RUN) begin
      p    = an ^ bn;
      g    = an & bn;
      c_in = carry_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sum_r     <= '0;
      carry_reg <= 1'b0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r       <= a;
`ifdef CLA_SEQ_SUB_EN
            b_r       <= op_sub ? ~b : b;
            carry_reg <= op_sub;
`else
            b_r       <= b;
            carry_reg <= 1'b0;
`endif
            idx       <= '0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_r[idx] <= sum_nib;
          carry_reg  <= c_out;
          idx        <= idx + 1'b1;
          if (idx == LAST) begin
            carry_out <= c_out;
            overflow  <= carry[3] ^ carry[2];
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed bench for cla_nibble_sequencer: an 8-bit and a 32-bit instance, each with a behavioural CLA slice.
module tb_cla_nibble_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic logic [3:0] cla(input logic [3:0] pp, input logic [3:0] gg, input logic ci);
    logic c;
    logic [3:0] r;
    c = ci;
    r = 4'h0;
    for (int i = 0; i < 4; i++) begin
      r[i] = gg[i] | (pp[i] & c);
      c    = r[i];
    end
    return r;
  endfunction

  // 8-bit instance
  logic       rst8, in_valid8, in_ready8, sub8, res_valid8, res_ready8;
  logic [7:0] a8, b8, sum8;
  logic       co8, ov8, z8, cin8, cout8;
  logic [3:0] p8, g8, carry8;
  assign carry8 = cla(p8, g8, cin8);
  assign cout8  = carry8[3];

  cla_nibble_sequencer #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .op_sub(sub8),
    .a(a8), .b(b8), .res_valid(res_valid8), .res_ready(res_ready8), .sum(sum8),
    .carry_out(co8), .overflow(ov8), .zero(z8), .p(p8), .g(g8), .c_in(cin8),
    .carry(carry8), .c_out(cout8)
  );

  // 32-bit instance
  logic        rst32, in_valid32, in_ready32, sub32, res_valid32, res_ready32;
  logic [31:0] a32, b32, sum32;
  logic        co32, ov32, z32, cin32, cout32;
  logic [3:0]  p32, g32, carry32;
  assign carry32 = cla(p32, g32, cin32);
  assign cout32  = carry32[3];

  cla_nibble_sequencer #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst32), .in_valid(in_valid32), .in_ready(in_ready32), .op_sub(sub32),
    .a(a32), .b(b32), .res_valid(res_valid32), .res_ready(res_ready32), .sum(sum32),
    .carry_out(co32), .overflow(ov32), .zero(z32), .p(p32), .g(g32), .c_in(cin32),
    .carry(carry32), .c_out(cout32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic sub,
                      output logic [7:0] s, output logic co, output logic ov,
                      output logic z, output int lat);
    a8 = av; b8 = bv; sub8 = sub; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!res_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum8; co = co8; ov = ov8; z = z8;
    res_ready8 = 1'b1;
    @(posedge clk); #1;
    res_ready8 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       sub;
    logic [7:0] sum;
    logic       co, ov, z;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] s;
    logic co, ov, z;
    int lat;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
`ifdef CLA_SEQ_SUB_EN
    vecs[4] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
`else
    // op_sub must be ignored: these behave as plain adds
    vecs[4] = '{8'h05, 8'h07, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
`endif

    rst8 = 1'b1; rst32 = 1'b1;
    in_valid8 = 0; sub8 = 0; a8 = 0; b8 = 0; res_ready8 = 0;
    in_valid32 = 0; sub32 = 0; a32 = 0; b32 = 0; res_ready32 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst8_in_ready", {31'b0, in_ready8}, 32'd1);
    chk("rst8_res_valid", {31'b0, res_valid8}, 32'd0);
    chk("rst8_sum", {24'b0, sum8}, 32'd0);
    chk("rst8_zero", {31'b0, z8}, 32'd1);
    chk("rst32_sum", sum32, 32'd0);
    chk("rst32_slice_idle", {27'b0, p32, cin32}, 32'd0);
    rst8 = 1'b0; rst32 = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].sub, s, co, ov, z, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd2);
      chk($sformatf("v%0d_sum", i), {24'b0, s}, {24'b0, vecs[i].sum});
      chk($sformatf("v%0d_carry_out", i), {31'b0, co}, {31'b0, vecs[i].co});
      chk($sformatf("v%0d_overflow", i), {31'b0, ov}, {31'b0, vecs[i].ov});
      chk($sformatf("v%0d_zero", i), {31'b0, z}, {31'b0, vecs[i].z});
      chk($sformatf("v%0d_in_ready_back", i), {31'b0, in_ready8}, 32'd1);
    end

    // Backpressure: 0x12 + 0x34 held in DONE while a competing request waits
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'hAA; b8 = 8'h55;
    lat = 0;
    while (!res_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, 32'd2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_sum_c%0d", k), {24'b0, sum8}, 32'h46);
      chk($sformatf("bp_flags_c%0d", k), {29'b0, co8, ov8, z8}, 32'd0);
      chk($sformatf("bp_in_ready_c%0d", k), {31'b0, in_ready8}, 32'd0);
      chk($sformatf("bp_res_valid_c%0d", k), {31'b0, res_valid8}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    res_ready8 = 1'b1;
    @(posedge clk); #1;
    res_ready8 = 1'b0;
    chk("bp_res_valid_drop", {31'b0, res_valid8}, 32'd0);
    chk("bp_in_ready_next", {31'b0, in_ready8}, 32'd1);
    chk("bp_sum_kept", {24'b0, sum8}, 32'h46);

    // 32-bit full carry ripple: c_in to slice is 0 on nibble 0 and 1 on nibbles 1..7
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("w32_c_in_n%0d", k), {31'b0, cin32}, (k > 0) ? 32'd1 : 32'd0);
      chk($sformatf("w32_not_done_n%0d", k), {31'b0, res_valid32}, 32'd0);
      @(posedge clk); #1;
    end
    chk("w32_res_valid_at_8", {31'b0, res_valid32}, 32'd1);
    chk("w32_sum", sum32, 32'd0);
    chk("w32_carry_out", {31'b0, co32}, 32'd1);
    chk("w32_zero", {31'b0, z32}, 32'd1);
    chk("w32_slice_idle", {27'b0, p32, cin32}, 32'd0);
    res_ready32 = 1'b1;
    @(posedge clk); #1;
    res_ready32 = 1'b0;

    // Reset in RUN cycle 1 aborts the op
    a32 = 32'h1111_1111; b32 = 32'h2222_2222; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    @(posedge clk); #1;
    chk("abort_partial_sum", sum32, 32'h0000_0003);
    rst32 = 1'b1;
    #1;
    chk("abort_in_ready", {31'b0, in_ready32}, 32'd1);
    chk("abort_res_valid", {31'b0, res_valid32}, 32'd0);
    chk("abort_sum", sum32, 32'd0);
    #2;
    rst32 = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_valid", {31'b0, res_valid32}, 32'd0);

    a32 = 32'd3; b32 = 32'd4; in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    lat = 0;
    while (!res_valid32 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("after_abort_latency", lat, 32'd8);
    chk("after_abort_sum", sum32, 32'd7);
    chk("after_abort_carry_out", {31'b0, co32}, 32'd0);
    res_ready32 = 1'b1;
    @(posedge clk); #1;
    res_ready32 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
